// File: rtl/riscv_branch_pkg.sv
// Shared opcode/funct3 constants and FSM state type for the branch PC controller.
package riscv_branch_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int FLUSH_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RESOLVE = 2'd1,
        FLUSH   = 2'd2
    } state_t;

endpackage

// File: rtl/branch_imm_decode.sv
// Combinational B-type immediate extraction: sign-extended, bit 0 forced to zero.
module branch_imm_decode (
    input  logic [31:0] Instruction_code,
    output logic [31:0] imm
);

    logic unused_rs_fields;
    assign unused_rs_fields = ^{Instruction_code[24:12], Instruction_code[6:0]};

    assign imm = {{19{Instruction_code[31]}}, Instruction_code[31], Instruction_code[7],
                  Instruction_code[30:25], Instruction_code[11:8], 1'b0};

endmodule

// File: rtl/branch_pc_controller.sv
// Sequences the PC around conditional branches: accept, resolve, fixed-length flush.
// Optional taken-branch statistics counter is built when BRANCH_STATS_EN is defined.
module branch_pc_controller
    import riscv_branch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] Instruction_code,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic [31:0] pc,
    output logic        flush,
    output logic        branch_taken,
    output logic        branch_fault,
`ifdef BRANCH_STATS_EN
    output logic [31:0] taken_count,
`endif
    output state_t      state_dbg
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    // Handshake: an instruction is consumed on a rising edge where instr_valid and
    // instr_ready are both high; ready is only offered in RUN and never during reset.
    state_t                 state;
    logic [31:0]            pc_lat;
    logic [31:0]            imm_lat;
    logic [31:0]            rs1_lat;
    logic [31:0]            rs2_lat;
    logic [2:0]             f3_lat;
    logic [FLUSH_CNT_W-1:0] cnt;
    logic [31:0]            imm_dec;
    logic [31:0]            target;
    logic                   f3_illegal;
    logic                   cond_true;
    logic                   redirect_ok;
    logic                   accept;
    logic                   is_branch;

    branch_imm_decode u_imm (
        .Instruction_code (Instruction_code),
        .imm              (imm_dec)
    );

    assign instr_ready = reset_n && (state == RUN);
    assign accept      = instr_valid && instr_ready;
    assign is_branch   = (Instruction_code[6:0] == OPC_BRANCH);
    assign target      = pc_lat + imm_lat;
    assign state_dbg   = state;

    always_comb begin
        cond_true  = 1'b0;
        f3_illegal = 1'b0;
        case (f3_lat)
            F3_BEQ:  cond_true = (rs1_lat == rs2_lat);
            F3_BNE:  cond_true = (rs1_lat != rs2_lat);
            F3_BLT:  cond_true = ($signed(rs1_lat) <  $signed(rs2_lat));
            F3_BGE:  cond_true = ($signed(rs1_lat) >= $signed(rs2_lat));
            F3_BLTU: cond_true = (rs1_lat <  rs2_lat);
            F3_BGEU: cond_true = (rs1_lat >= rs2_lat);
            default: f3_illegal = 1'b1;
        endcase
    end

    assign redirect_ok = !f3_illegal && cond_true && (target[1:0] == 2'b00);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= RUN;
            pc           <= RESET_PC;
            flush        <= 1'b0;
            branch_taken <= 1'b0;
            branch_fault <= 1'b0;
            cnt          <= '0;
            pc_lat       <= '0;
            imm_lat      <= '0;
            rs1_lat      <= '0;
            rs2_lat      <= '0;
            f3_lat       <= '0;
        end else begin
            branch_taken <= 1'b0;
            branch_fault <= 1'b0;
            case (state)
                RUN: begin
                    if (accept) begin
                        if (is_branch) begin
                            pc_lat  <= pc;
                            imm_lat <= imm_dec;
                            f3_lat  <= Instruction_code[14:12];
                            rs1_lat <= rs1_data;
                            rs2_lat <= rs2_data;
                            state   <= RESOLVE;
                        end else begin
                            pc <= pc + 32'd4;
                        end
                    end
                end
                RESOLVE: begin
                    if (redirect_ok) begin
                        pc           <= target;
                        branch_taken <= 1'b1;
                        flush        <= 1'b1;
                        cnt          <= FLUSH_INIT;
                        state        <= FLUSH;
                    end else begin
                        // Illegal funct3 and misaligned taken targets both fall through.
                        branch_fault <= f3_illegal || cond_true;
                        pc           <= pc_lat + 32'd4;
                        state        <= RUN;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        flush <= 1'b0;
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_count <= '0;
        end else if (state == RESOLVE && redirect_ok && taken_count != 32'hFFFF_FFFF) begin
            taken_count <= taken_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_controller.sv
// Directed self-checking bench for branch_pc_controller (RESET_PC=0x100, FLUSH_CYCLES=2).
module tb_branch_pc_controller;
  import riscv_branch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instruction_code;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] pc;
  logic        flush;
  logic        branch_taken;
  logic        branch_fault;
  state_t      state_dbg;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;
`endif

  int asserts = 0;
  int fails   = 0;

  branch_pc_controller #(.RESET_PC(RST_PC), .FLUSH_CYCLES(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .Instruction_code (Instruction_code),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .pc               (pc),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_fault     (branch_fault),
`ifdef BRANCH_STATS_EN
    .taken_count      (taken_count),
`endif
    .state_dbg        (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // B-type encoder: the bench builds instruction words from a signed byte offset.
  function automatic logic [31:0] make_b(input logic [2:0] f3, input int off);
    logic [12:0] i;
    i = 13'(off);
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], OPC_BRANCH};
  endfunction

  // driver tasks: always entered and left on a falling edge
  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 32) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      asserts++;
      fails++;
      $display("FAIL ready_timeout: instr_ready=%0b after %0d cycles, required 1", instr_ready, n);
    end
  endtask

  task automatic send(input logic [31:0] ic, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    Instruction_code = ic;
    rs1_data         = a;
    rs2_data         = b;
    instr_valid      = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  // issue a branch and return at the falling edge after its resolve edge
  task automatic branch(input logic [2:0] f3, input int off, input logic [31:0] a, input logic [31:0] b);
    send(make_b(f3, off), a, b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    asserts++; if (instr_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b required 0", instr_ready); end
    asserts++; if (pc !== RST_PC) begin fails++; $display("FAIL rst_pc: got %h required %h", pc, RST_PC); end
    asserts++; if ({flush, branch_taken, branch_fault} !== 3'b000) begin fails++; $display("FAIL rst_flags: got %b required 000", {flush, branch_taken, branch_fault}); end
`ifdef BRANCH_STATS_EN
    asserts++; if (taken_count !== 32'd0) begin fails++; $display("FAIL rst_count: got %0d required 0", taken_count); end
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    asserts++; if (state_dbg !== RUN || instr_ready !== 1'b1) begin fails++; $display("FAIL rst_run: state %0d ready %b required 0/1", state_dbg, instr_ready); end
  endtask

  task automatic test_beq();
    int ready_low = 0;
    int flush_hi  = 0;
    int taken_n   = 0;
    send(make_b(F3_BEQ, 8), 32'd5, 32'd5);
    asserts++; if (pc !== 32'h100) begin fails++; $display("FAIL beq_pc_accept: got %h required 00000100", pc); end
    if (!instr_ready) ready_low++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        asserts++; if (pc !== 32'h108) begin fails++; $display("FAIL beq_pc_resolve: got %h required 00000108", pc); end
      end
      if (!instr_ready) ready_low++;
      if (flush) flush_hi++;
      if (branch_taken) taken_n++;
    end
    asserts++; if (ready_low != 3) begin fails++; $display("FAIL beq_ready_low: got %0d required 3", ready_low); end
    asserts++; if (flush_hi != 2) begin fails++; $display("FAIL beq_flush_len: got %0d required 2", flush_hi); end
    asserts++; if (taken_n != 1) begin fails++; $display("FAIL beq_taken_pulse: got %0d required 1", taken_n); end
  endtask

  task automatic test_no_accept();
    instr_valid      = 1'b0;
    Instruction_code = NOP;
    repeat (3) @(negedge clk);
    asserts++; if (pc !== 32'h108) begin fails++; $display("FAIL no_accept_pc: got %h required 00000108", pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    exp_pc = 32'h108;
    Instruction_code = NOP;
    instr_valid      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_pc = exp_pc + 32'd4;
      asserts++; if (pc !== exp_pc) begin fails++; $display("FAIL b2b_pc%0d: got %h required %h", i, pc, exp_pc); end
    end
    instr_valid = 1'b0;
  endtask

  task automatic test_conditions();
    logic [2:0]  f3_t [13] = '{F3_BEQ, F3_BEQ, F3_BNE, F3_BNE, F3_BLT, F3_BLT, F3_BGE, F3_BGE,
                               F3_BGE, F3_BLTU, F3_BLTU, F3_BGEU, F3_BGEU};
    logic [31:0] a_t  [13] = '{32'd5, 32'd5, 32'd5, 32'd7, 32'hFFFF_FFFF, 32'd1, 32'd1,
                               32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] b_t  [13] = '{32'd5, 32'd6, 32'd6, 32'd7, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'd2};
    logic        tk_t [13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_pc;
    exp_pc = 32'h114;
    for (int i = 0; i < 13; i++) begin
      branch(f3_t[i], 8, a_t[i], b_t[i]);
      exp_pc = exp_pc + (tk_t[i] ? 32'd8 : 32'd4);
      asserts++; if (pc !== exp_pc || branch_taken !== tk_t[i]) begin
        fails++; $display("FAIL cond%0d: pc %h taken %b required %h %b", i, pc, branch_taken, exp_pc, tk_t[i]);
      end
      wait_ready();
    end
  endtask

  task automatic test_bne_backward();
    apply_reset();
    branch(F3_BEQ, 4092, 32'd0, 32'd0);
    wait_ready();
    branch(F3_BEQ, 3844, 32'd0, 32'd0);
    wait_ready();
    asserts++; if (pc !== 32'h2000) begin fails++; $display("FAIL fwd_pc: got %h required 00002000", pc); end
    branch(F3_BNE, -4096, 32'd1, 32'd2);
    asserts++; if (pc !== 32'h1000) begin fails++; $display("FAIL bne_back_pc: got %h required 00001000", pc); end
    wait_ready();
  endtask

  task automatic test_fault();
    apply_reset();
    branch(3'b010, 8, 32'd1, 32'd1);
    asserts++; if (branch_fault !== 1'b1 || pc !== 32'h104 || flush !== 1'b0) begin
      fails++; $display("FAIL f3_fault: fault %b pc %h flush %b required 1 00000104 0", branch_fault, pc, flush);
    end
    @(negedge clk);
    asserts++; if (branch_fault !== 1'b0) begin fails++; $display("FAIL f3_fault_pulse: got %b required 0", branch_fault); end
    apply_reset();
    branch(F3_BEQ, 2, 32'd3, 32'd3);
    asserts++; if (branch_fault !== 1'b1 || branch_taken !== 1'b0 || pc !== 32'h104 || flush !== 1'b0) begin
      fails++; $display("FAIL misalign: fault %b taken %b pc %h flush %b required 1 0 00000104 0", branch_fault, branch_taken, pc, flush);
    end
    wait_ready();
  endtask

  task automatic test_wrap();
    apply_reset();
    branch(F3_BEQ, -260, 32'd0, 32'd0);
    wait_ready();
    asserts++; if (pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_setup: got %h required fffffffc", pc); end
    send(NOP, 32'd0, 32'd0);
    asserts++; if (pc !== 32'h0000_0000) begin fails++; $display("FAIL wrap_pc: got %h required 00000000", pc); end
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    branch(F3_BEQ, 16, 32'd9, 32'd9);
    asserts++; if (flush !== 1'b1 || state_dbg !== FLUSH) begin fails++; $display("FAIL rif_setup: flush %b state %0d required 1 2", flush, state_dbg); end
    reset_n = 1'b0;
    #1;
    asserts++; if (pc !== RST_PC || flush !== 1'b0 || instr_ready !== 1'b0 || state_dbg !== RUN) begin
      fails++; $display("FAIL rif_abort: pc %h flush %b ready %b state %0d required 00000100 0 0 0", pc, flush, instr_ready, state_dbg);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      branch(F3_BEQ, 8, 32'd1, 32'd1);
      wait_ready();
    end
    branch(F3_BNE, 8, 32'd1, 32'd1);
    wait_ready();
    asserts++; if (taken_count !== 32'd3) begin fails++; $display("FAIL stats_count: got %0d required 3", taken_count); end
  endtask
`endif

  initial begin
    instr_valid      = 1'b0;
    Instruction_code = NOP;
    rs1_data         = '0;
    rs2_data         = '0;
    reset_n          = 1'b0;
    @(negedge clk);
    test_reset();
    test_beq();
    test_no_accept();
    test_back_to_back();
    test_conditions();
    test_bne_backward();
    test_fault();
    test_wrap();
    test_reset_in_flush();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
